// File: rtl/store_result_monitor.sv
`default_nettype none
// ============================================================================
// Module   : store_result_monitor
// Brief    : Watches the CPU data-memory write port. Counts RUN cycles and
//            stores, decides pass/fail on the result-word store, and flags
//            misaligned stores and timeouts. An optional store-log FIFO is
//            built when the macro STORE_MON_LOG_EN is defined. Without it the
//            log outputs are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module store_result_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd84,
    parameter logic [31:0] PASS_DATA      = 32'd7,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 16,
    parameter int          LOG_DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active low
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] store_cnt,
    output logic [31:0]      last_addr,
    output logic [31:0]      last_data,
    output logic             log_valid,
    input  logic             log_ready,
    output logic [31:0]      log_addr,
    output logic [31:0]      log_data,
    output logic             log_overflow
);

    localparam logic [1:0] c_ST_RUN  = 2'd0;
    localparam logic [1:0] c_ST_PASS = 2'd1;
    localparam logic [1:0] c_ST_FAIL = 2'd2;

    localparam logic [1:0] c_FC_NONE  = 2'd0;
    localparam logic [1:0] c_FC_DATA  = 2'd1;
    localparam logic [1:0] c_FC_ALIGN = 2'd2;
    localparam logic [1:0] c_FC_TMO   = 2'd3;

    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE      = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_fail_code;
    logic [1:0]       w_fail_code_nxt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_store_cnt;
    logic [31:0]      r_last_addr;
    logic [31:0]      r_last_data;
    logic             w_run;
    logic             w_store;

    assign w_run   = (r_state == c_ST_RUN);
    assign w_store = w_run && memwrite;

    // State and fail-code registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_RUN;
            r_fail_code <= c_FC_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_fail_code <= w_fail_code_nxt;
        end
    end

    // Next-state decode: misaligned beats result store beats timeout
    always_comb begin
        w_state_nxt     = r_state;
        w_fail_code_nxt = r_fail_code;
        if (w_run) begin
            if (memwrite && (dataadr[1:0] != 2'b00)) begin
                w_state_nxt     = c_ST_FAIL;
                w_fail_code_nxt = c_FC_ALIGN;
            end else if (memwrite && (dataadr == PASS_ADDR)) begin
                if (writedata == PASS_DATA) begin
                    w_state_nxt = c_ST_PASS;
                end else begin
                    w_state_nxt     = c_ST_FAIL;
                    w_fail_code_nxt = c_FC_DATA;
                end
            end else if (r_cycle_cnt == c_TIMEOUT_LAST) begin
                w_state_nxt     = c_ST_FAIL;
                w_fail_code_nxt = c_FC_TMO;
            end
        end
    end

    // RUN-only counters (saturating) and last-store capture; the terminating edge still counts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt <= '0;
            r_store_cnt <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
        end else if (w_run) begin
            if (r_cycle_cnt != c_CNT_MAX) begin
                r_cycle_cnt <= r_cycle_cnt + c_CNT_ONE;
            end
            if (memwrite) begin
                if (r_store_cnt != c_CNT_MAX) begin
                    r_store_cnt <= r_store_cnt + c_CNT_ONE;
                end
                r_last_addr <= dataadr;
                r_last_data <= writedata;
            end
        end
    end

    assign done      = (r_state != c_ST_RUN);
    assign pass      = (r_state == c_ST_PASS);
    assign fail_code = r_fail_code;
    assign cycle_cnt = r_cycle_cnt;
    assign store_cnt = r_store_cnt;
    assign last_addr = r_last_addr;
    assign last_data = r_last_data;

`ifdef STORE_MON_LOG_EN
    localparam int                c_PTR_W   = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam logic [c_PTR_W:0]  c_FULL    = (c_PTR_W + 1)'(LOG_DEPTH);
    localparam logic [c_PTR_W:0]  c_LCNT_1  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_1  = c_PTR_W'(1);

    logic [31:0]        r_mem_addr [LOG_DEPTH];
    logic [31:0]        r_mem_data [LOG_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    assign w_full = (r_count == c_FULL);
    assign w_pop  = (r_count != '0) && log_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the store
    assign w_push = w_store && (!w_full || w_pop);
    assign w_drop = w_store && w_full && !w_pop;

    // Log storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= dataadr;
            r_mem_data[r_wr_ptr] <= writedata;
        end
    end

    // Log pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_LCNT_1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_LCNT_1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign log_valid    = (r_count != '0);
    assign log_addr     = r_mem_addr[r_rd_ptr];
    assign log_data     = r_mem_data[r_rd_ptr];
    assign log_overflow = r_overflow;
`else
    logic w_unused_log;
    assign w_unused_log = log_ready | (LOG_DEPTH == 0);

    assign log_valid    = 1'b0;
    assign log_addr     = '0;
    assign log_data     = '0;
    assign log_overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_result_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_result_monitor
// Brief    : Directed self-checking bench for store_result_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_result_monitor;

    localparam int c_CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               memwrite = 1'b0;
    logic [31:0]        dataadr = '0;
    logic [31:0]        writedata = '0;
    logic               done;
    logic               pass;
    logic [1:0]         fail_code;
    logic [c_CNT_W-1:0] cycle_cnt;
    logic [c_CNT_W-1:0] store_cnt;
    logic [31:0]        last_addr;
    logic [31:0]        last_data;
    logic               log_valid;
    logic               log_ready = 1'b0;
    logic [31:0]        log_addr;
    logic [31:0]        log_data;
    logic               log_overflow;

    int n_vec = 0;
    int n_err = 0;

    store_result_monitor #(
        .PASS_ADDR      (32'd84),
        .PASS_DATA      (32'd7),
        .TIMEOUT_CYCLES (20),
        .CNT_W          (c_CNT_W),
        .LOG_DEPTH      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .memwrite     (memwrite),
        .dataadr      (dataadr),
        .writedata    (writedata),
        .done         (done),
        .pass         (pass),
        .fail_code    (fail_code),
        .cycle_cnt    (cycle_cnt),
        .store_cnt    (store_cnt),
        .last_addr    (last_addr),
        .last_data    (last_data),
        .log_valid    (log_valid),
        .log_ready    (log_ready),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_overflow (log_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs driven at negedge, sampled by DUT at posedge, bench checks at next negedge
    task automatic tick(input logic mw, input logic [31:0] a, input logic [31:0] d);
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
        @(posedge clk);
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 32'd0);
    endtask

    task automatic reset_dut();
        rst       = 1'b0;
        memwrite  = 1'b0;
        log_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // ---- reset state ----
        reset_dut();
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_fc", {30'd0, fail_code}, 32'd0);
        chk("rst_cyc", {16'd0, cycle_cnt}, 32'd0);
        chk("rst_st", {16'd0, store_cnt}, 32'd0);
        chk("rst_valid", {31'd0, log_valid}, 32'd0);

        // ---- 1. pass: stores at cycles 3 and 8 ----
        idle(3);
        tick(1'b1, 32'h10, 32'd5);
        chk("p_st1", {16'd0, store_cnt}, 32'd1);
        chk("p_la1", last_addr, 32'h10);
        chk("p_done_early", {31'd0, done}, 32'd0);
        idle(4);
        tick(1'b1, 32'd84, 32'd7);
        chk("p_pass", {31'd0, pass}, 32'd1);
        chk("p_done", {31'd0, done}, 32'd1);
        chk("p_fc", {30'd0, fail_code}, 32'd0);
        chk("p_st", {16'd0, store_cnt}, 32'd2);
        chk("p_la", last_addr, 32'd84);
        chk("p_ld", last_data, 32'd7);
        chk("p_cyc", {16'd0, cycle_cnt}, 32'd9);
`ifdef STORE_MON_LOG_EN
        chk("p_log_valid", {31'd0, log_valid}, 32'd1);
        chk("p_log_head", log_addr, 32'h10);
`endif
        tick(1'b1, 32'd84, 32'd0);
        idle(2);
        chk("p_frz_pass", {31'd0, pass}, 32'd1);
        chk("p_frz_st", {16'd0, store_cnt}, 32'd2);
        chk("p_frz_ld", last_data, 32'd7);
        chk("p_frz_cyc", {16'd0, cycle_cnt}, 32'd9);

        // ---- 2. wrong data ----
        reset_dut();
        tick(1'b1, 32'd84, 32'd6);
        chk("wd_done", {31'd0, done}, 32'd1);
        chk("wd_pass", {31'd0, pass}, 32'd0);
        chk("wd_fc", {30'd0, fail_code}, 32'd1);

        // ---- 3. misaligned ----
        reset_dut();
        tick(1'b1, 32'h56, 32'd7);
        chk("ma_fc", {30'd0, fail_code}, 32'd2);
        chk("ma_st", {16'd0, store_cnt}, 32'd1);
        chk("ma_done", {31'd0, done}, 32'd1);
        chk("ma_pass", {31'd0, pass}, 32'd0);

        // ---- 4. timeout, then result store on the timeout edge ----
        reset_dut();
        idle(19);
        chk("to_cyc19", {16'd0, cycle_cnt}, 32'd19);
        chk("to_done_pre", {31'd0, done}, 32'd0);
        idle(1);
        chk("to_fc", {30'd0, fail_code}, 32'd3);
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_cyc", {16'd0, cycle_cnt}, 32'd20);
        idle(3);
        chk("to_cyc_frz", {16'd0, cycle_cnt}, 32'd20);
        reset_dut();
        idle(19);
        tick(1'b1, 32'd84, 32'd7);
        chk("tp_pass", {31'd0, pass}, 32'd1);
        chk("tp_fc", {30'd0, fail_code}, 32'd0);

        // ---- 5. store log ----
        reset_dut();
        for (int i = 0; i < 6; i++) tick(1'b1, 32'(4 * i), 32'(100 + i));
        chk("f_st6", {16'd0, store_cnt}, 32'd6);
        chk("f_la", last_addr, 32'd20);
`ifdef STORE_MON_LOG_EN
        chk("f_ovf", {31'd0, log_overflow}, 32'd1);
        log_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("f_pop_valid", {31'd0, log_valid}, 32'd1);
            chk("f_pop_addr", log_addr, 32'(4 * i));
            chk("f_pop_data", log_data, 32'(100 + i));
            idle(1);
        end
        chk("f_empty", {31'd0, log_valid}, 32'd0);

        reset_dut();
        log_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b1, 32'(4 * i), 32'(100 + i));
        chk("fr_ovf", {31'd0, log_overflow}, 32'd0);
        chk("fr_head", log_addr, 32'd20);
        idle(1);
        chk("fr_empty", {31'd0, log_valid}, 32'd0);

        // push and pop together while full: nothing dropped
        reset_dut();
        for (int i = 0; i < 4; i++) tick(1'b1, 32'(4 * i), 32'(100 + i));
        log_ready = 1'b1;
        tick(1'b1, 32'd16, 32'd104);
        log_ready = 1'b0;
        chk("ff_ovf", {31'd0, log_overflow}, 32'd0);
        chk("ff_head", log_addr, 32'd4);
        log_ready = 1'b1;
        idle(3);
        chk("ff_tail", log_addr, 32'd16);
        chk("ff_tail_d", log_data, 32'd104);
        log_ready = 1'b0;
`else
        chk("f_ovf_off", {31'd0, log_overflow}, 32'd0);
        chk("f_valid_off", {31'd0, log_valid}, 32'd0);
        chk("f_addr_off", log_addr, 32'd0);
`endif

        // ---- 6. asynchronous reset mid-run ----
        reset_dut();
        tick(1'b1, 32'd0, 32'd1);
        tick(1'b1, 32'd4, 32'd2);
        log_ready = 1'b1;
        tick(1'b1, 32'd8, 32'd3);
        log_ready = 1'b0;
        chk("ar_st_pre", {16'd0, store_cnt}, 32'd3);
`ifdef STORE_MON_LOG_EN
        chk("ar_valid_pre", {31'd0, log_valid}, 32'd1);
        chk("ar_head_pre", log_addr, 32'd4);
`endif
        #2;
        rst = 1'b0;
        #1;
        chk("ar_cyc", {16'd0, cycle_cnt}, 32'd0);
        chk("ar_st", {16'd0, store_cnt}, 32'd0);
        chk("ar_la", last_addr, 32'd0);
        chk("ar_ld", last_data, 32'd0);
        chk("ar_valid", {31'd0, log_valid}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
